// File: rtl/apple2_timing_gen_pkg.sv
// Shared Apple II master-timing constants and the phi0/q3 level decode used by the timing generator.
package apple2_timing_gen_pkg;

    localparam int unsigned CLK_DIV_DEF         = 4;
    localparam int unsigned TICKS_PER_CYC_DEF   = 14;
    localparam int unsigned TICKS_LONG_CYC_DEF  = 16;
    localparam int unsigned CYCLES_PER_LINE_DEF = 65;
    localparam int unsigned LINES_PER_FRAME_DEF = 262;
    localparam int unsigned RST_HOLD_DEF        = 1024;
    localparam int unsigned SYNC_STAGES_DEF     = 2;

    // Tick thresholds inside a CPU cycle: phi0 rises at 7, q3 drops at 4 and again at 11.
    localparam int unsigned PHI0_RISE_TICK = 7;
    localparam int unsigned Q3_LOW1_TICK   = 4;
    localparam int unsigned Q3_LOW2_TICK   = 11;

    function automatic logic phi0_level(input int unsigned tick);
        return tick >= PHI0_RISE_TICK;
    endfunction

    function automatic logic q3_level(input int unsigned tick);
        return (tick < Q3_LOW1_TICK) || ((tick >= PHI0_RISE_TICK) && (tick < Q3_LOW2_TICK));
    endfunction

endpackage

// File: rtl/apple2_timing_gen_if.sv
// Timing bundle between the PLL-side generator (master) and the Apple II core (slave).
interface apple2_timing_gen_if;
    logic       pll_locked;
    logic       pause;
    logic       core_reset;
    logic       ce_14m;
    logic       ce_7m;
    logic       ce_phi0_rise;
    logic       ce_phi0_fall;
    logic       phi0;
    logic       q3;
    logic [6:0] line_cyc;
    logic [8:0] line_num;
    logic       frame_start;

    modport master (
        input  pll_locked, pause,
        output core_reset, ce_14m, ce_7m, ce_phi0_rise, ce_phi0_fall,
               phi0, q3, line_cyc, line_num, frame_start
    );

    modport slave (
        output pll_locked, pause,
        input  core_reset, ce_14m, ce_7m, ce_phi0_rise, ce_phi0_fall,
               phi0, q3, line_cyc, line_num, frame_start
    );
endinterface

// File: rtl/apple2_timing_gen_pll_lock_reset.sv
// Synchronises pll_locked into clk and holds core_reset for RST_HOLD clks after lock and rst release.
module apple2_timing_gen_pll_lock_reset #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_HOLD    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked_i,
    output logic core_reset_o,
    output logic core_reset_next_o
);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [HOLD_W-1:0]      hold_d;
    logic                   core_reset_q;
    logic                   core_reset_d;
    logic                   lk_s;

    assign lk_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) sync_q[0] <= 1'b0;
        else     sync_q[0] <= pll_locked_i;
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) sync_q[gi] <= 1'b0;
            else     sync_q[gi] <= sync_q[gi-1];
        end
    end

    // Counter saturates at RST_HOLD; any rst or lock loss restarts the whole hold.
    always_comb begin
        hold_d = hold_q;
        if (rst || !lk_s) begin
            hold_d = '0;
        end else if (hold_q != HOLD_W'(RST_HOLD)) begin
            hold_d = hold_q + 1'b1;
        end
        core_reset_d = (hold_d != HOLD_W'(RST_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            core_reset_q <= 1'b1;
        end else begin
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign core_reset_o      = core_reset_q;
    assign core_reset_next_o = core_reset_d;
endmodule

// File: rtl/apple2_timing_gen.sv
// Apple II master timing: 14M/7M enables, phi0/q3 levels, stretched 65th cycle, line/frame counters.
module apple2_timing_gen
    import apple2_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV         = CLK_DIV_DEF,
    parameter int unsigned TICKS_PER_CYC   = TICKS_PER_CYC_DEF,
    parameter int unsigned TICKS_LONG_CYC  = TICKS_LONG_CYC_DEF,
    parameter int unsigned CYCLES_PER_LINE = CYCLES_PER_LINE_DEF,
    parameter int unsigned LINES_PER_FRAME = LINES_PER_FRAME_DEF,
    parameter int unsigned RST_HOLD        = RST_HOLD_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    apple2_timing_gen_if.master bus_if
);
    localparam int unsigned D_W    = $clog2(CLK_DIV);
    localparam int unsigned T_W    = $clog2(TICKS_LONG_CYC);
    localparam int unsigned CYC_W  = $clog2(CYCLES_PER_LINE);
    localparam int unsigned LINE_W = $clog2(LINES_PER_FRAME);

    logic              core_reset_w;
    logic              core_reset_next_w;
    logic              hold_w;
    logic              tick_en;
    logic              last_cyc;
    logic              last_line;
    logic [T_W-1:0]    tick_last;

    logic [D_W-1:0]    div_q, div_d;
    logic [T_W-1:0]    tick_q, tick_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              ce_14m_q, ce_14m_d;
    logic              ce_7m_q, ce_7m_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              phi0_q, phi0_d;
    logic              q3_q, q3_d;
    logic              frame_q, frame_d;

    apple2_timing_gen_pll_lock_reset #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_HOLD    (RST_HOLD)
    ) u_lock_reset (
        .clk               (clk),
        .rst               (rst),
        .pll_locked_i      (bus_if.pll_locked),
        .core_reset_o      (core_reset_w),
        .core_reset_next_o (core_reset_next_w)
    );

    // Registered reset releases the counters one clk late; the next-state term clears them
    // on the same clk that core_reset rises, so counters never show nonzero under reset.
    assign hold_w    = core_reset_w | core_reset_next_w;
    assign tick_en   = (div_q == D_W'(CLK_DIV - 1));
    assign last_cyc  = (cyc_q == CYC_W'(CYCLES_PER_LINE - 1));
    assign last_line = (line_q == LINE_W'(LINES_PER_FRAME - 1));
    assign tick_last = last_cyc ? T_W'(TICKS_LONG_CYC - 1) : T_W'(TICKS_PER_CYC - 1);

    always_comb begin
        div_d    = div_q + 1'b1;
        tick_d   = tick_q;
        cyc_d    = cyc_q;
        line_d   = line_q;
        ce_14m_d = 1'b0;
        ce_7m_d  = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        frame_d  = 1'b0;
        phi0_d   = phi0_q;
        q3_d     = q3_q;

        if (tick_en) begin
            div_d    = '0;
            ce_14m_d = 1'b1;
            ce_7m_d  = tick_q[0];
            rise_d   = (tick_q == T_W'(PHI0_RISE_TICK - 1)) && !bus_if.pause;
            if (tick_q == tick_last) begin
                tick_d = '0;
                fall_d = 1'b1;
                if (last_cyc) begin
                    cyc_d = '0;
                    if (last_line) begin
                        line_d  = '0;
                        frame_d = 1'b1;
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
            phi0_d = phi0_level(32'(tick_d));
            q3_d   = q3_level(32'(tick_d));
        end

        if (hold_w) begin
            div_d    = '0;
            tick_d   = '0;
            cyc_d    = '0;
            line_d   = '0;
            ce_14m_d = 1'b0;
            ce_7m_d  = 1'b0;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            frame_d  = 1'b0;
            phi0_d   = 1'b0;
            q3_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            tick_q   <= '0;
            cyc_q    <= '0;
            line_q   <= '0;
            ce_14m_q <= 1'b0;
            ce_7m_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            frame_q  <= 1'b0;
            phi0_q   <= 1'b0;
            q3_q     <= 1'b1;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            cyc_q    <= cyc_d;
            line_q   <= line_d;
            ce_14m_q <= ce_14m_d;
            ce_7m_q  <= ce_7m_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            frame_q  <= frame_d;
            phi0_q   <= phi0_d;
            q3_q     <= q3_d;
        end
    end

    assign bus_if.core_reset   = core_reset_w;
    assign bus_if.ce_14m       = ce_14m_q;
    assign bus_if.ce_7m        = ce_7m_q;
    assign bus_if.ce_phi0_rise = rise_q;
    assign bus_if.ce_phi0_fall = fall_q;
    assign bus_if.phi0         = phi0_q;
    assign bus_if.q3           = q3_q;
    assign bus_if.line_cyc     = 7'(cyc_q);
    assign bus_if.line_num     = 9'(line_q);
    assign bus_if.frame_start  = frame_q;
endmodule

// File: tb/tb_apple2_timing_gen.sv
// Randomised bench for apple2_timing_gen against a frame-position arithmetic reference model.
module tb_apple2_timing_gen;
    localparam int DIV       = 4;
    localparam int TPC       = 14;
    localparam int TLC       = 16;
    localparam int CPL       = 65;
    localparam int LPF       = 3;
    localparam int HOLD      = 40;
    localparam int SYNC      = 2;
    localparam int LINE_T    = TPC * (CPL - 1) + TLC;
    localparam int LINE_CLK  = LINE_T * DIV;
    localparam int FRAME_CLK = LINE_CLK * LPF;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   drop_e;
    int   total;

    apple2_timing_gen_if tif ();

    apple2_timing_gen #(
        .CLK_DIV         (DIV),
        .TICKS_PER_CYC   (TPC),
        .TICKS_LONG_CYC  (TLC),
        .CYCLES_PER_LINE (CPL),
        .LINES_PER_FRAME (LPF),
        .RST_HOLD        (HOLD),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (tif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Absolute tick position inside a frame -> (cycle, tick in cycle, line).
    function automatic void pos_fields(input int p, output int cyc, output int t, output int line);
        int q;
        int pl;
        q    = p % (LINE_T * LPF);
        line = q / LINE_T;
        pl   = q % LINE_T;
        if (pl < TPC * (CPL - 1)) begin
            cyc = pl / TPC;
            t   = pl % TPC;
        end else begin
            cyc = CPL - 1;
            t   = pl - TPC * (CPL - 1);
        end
    endfunction

    // n = clks since release (0 while held); all timing follows from n/DIV ticks elapsed.
    function automatic logic [23:0] model_outs(input bit cr, input int n, input bit pz);
        int  cyc, t, line, cp, tp, lp;
        bit  tick, ce7, rise, fall, fs, ph, q3;
        if (n == 0) return {cr, 6'b000001, 7'd0, 9'd0, 1'b0};
        tick = (n % DIV) == 0;
        pos_fields(n / DIV, cyc, t, line);
        ph   = (t >= 7);
        q3   = (t < 4) || (t >= 7 && t < 11);
        ce7  = 1'b0;
        rise = 1'b0;
        fall = 1'b0;
        fs   = 1'b0;
        if (tick) begin
            pos_fields(n / DIV - 1, cp, tp, lp);
            ce7  = (tp % 2) == 1;
            rise = (tp == 6) && !pz;
            fall = (t == 0);
            fs   = fall && (cyc == 0) && (line == 0);
        end
        return {cr, tick, ce7, rise, fall, ph, q3, 7'(cyc), 9'(line), fs};
    endfunction

    task automatic apply_inputs(input int k);
        rst            = (k < 10);
        tif.pll_locked = !(k >= drop_e && k < drop_e + 5);
        if (k >= 6000 && k < 9000) tif.pause = 1'b1;
        else                       tif.pause = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        logic [2:0]  rst_h;
        logic [2:0]  lock_h;
        logic [23:0] got;
        logic [8:0]  prev_line;
        int  last_bad, n, rel_start, rel_edge, drop_start, line_t, frame_t, ph_t;
        int  releases, drops, frames, prise, pfall;
        bit  cr, prev_cr, pz, rel_wait, drop_wait, ce_wait, timing_ok, ph_valid, ph_long, prev_phi0;

        checks = 0; errors = 0;
        drop_e = 24000 + int'($urandom_range(0, 3647));
        total  = drop_e + 6000;
        rst_h = 3'b111; lock_h = 3'b000; last_bad = 0; n = 0; prev_cr = 1'b1;
        rel_start = 0; rel_edge = 0; drop_start = 0; line_t = 0; frame_t = 0; ph_t = 0;
        releases = 0; drops = 0; frames = 0; prise = 0; pfall = 0;
        rel_wait = 0; drop_wait = 0; ce_wait = 0; timing_ok = 0; ph_valid = 0; ph_long = 0;
        prev_line = '0; prev_phi0 = 1'b0;
        apply_inputs(0);

        for (int e = 0; e < total; e++) begin
            @(posedge clk);
            rst_h  = {rst_h[1:0], rst};
            lock_h = {lock_h[1:0], tif.pll_locked};
            pz     = tif.pause;
            if (rst_h != 3'b000 || !lock_h[2]) last_bad = e;
            cr      = (e - last_bad) < HOLD;
            n       = (cr || prev_cr) ? 0 : n + 1;
            prev_cr = cr;
            if (!rst_h[0] && rst_h[1]) begin
                rel_start = e; rel_wait = 1;
            end else if (!rst_h[0] && lock_h[0] && !lock_h[1]) begin
                rel_start = e; rel_wait = 1;
            end
            if (lock_h[1] && !lock_h[0]) begin
                drop_start = e; drop_wait = 1;
            end

            #1;
            got = {tif.core_reset, tif.ce_14m, tif.ce_7m, tif.ce_phi0_rise, tif.ce_phi0_fall,
                   tif.phi0, tif.q3, tif.line_cyc, tif.line_num, tif.frame_start};
            check_val("outs", 32'(got), 32'(model_outs(cr, n, pz)));

            if (rel_wait && !tif.core_reset) begin
                check_val("release_latency", e - rel_start + 1, HOLD + SYNC);
                $display("release at clk %0d after %0d clks", e, e - rel_start + 1);
                rel_wait = 0; rel_edge = e; ce_wait = 1; line_t = e; frame_t = e;
                timing_ok = 1; releases++;
            end
            if (drop_wait && tif.core_reset) begin
                check_val("drop_latency", e - drop_start + 1, SYNC + 1);
                $display("lock drop at clk %0d -> core_reset after %0d clks", drop_start, e - drop_start + 1);
                drop_wait = 0; drops++;
            end
            if (tif.core_reset) begin
                timing_ok = 0; ph_valid = 0; ce_wait = 0;
            end else if (timing_ok) begin
                if (ce_wait && tif.ce_14m) begin
                    check_val("first_ce14m", e - rel_edge, DIV);
                    ce_wait = 0;
                end
                if (tif.line_num != prev_line) begin
                    check_val("line_clks", e - line_t, LINE_CLK);
                    $display("line %0d -> %0d at clk %0d (%0d clks)", prev_line, tif.line_num, e, e - line_t);
                    line_t = e;
                end
                if (tif.frame_start) begin
                    check_val("frame_clks", e - frame_t, FRAME_CLK);
                    $display("frame_start at clk %0d (%0d clks)", e, e - frame_t);
                    frame_t = e; frames++;
                end
                if (tif.phi0 && !prev_phi0) begin
                    ph_t = e; ph_valid = 1; ph_long = (tif.line_cyc == 7'(CPL - 1));
                end
                if (!tif.phi0 && prev_phi0 && ph_valid) begin
                    if (ph_long) check_val("phi0_high_long", e - ph_t, (TLC - 7) * DIV);
                    else         check_val("phi0_high", e - ph_t, (TPC - 7) * DIV);
                end
                if (pz && tif.ce_phi0_rise) prise++;
                if (pz && tif.ce_phi0_fall) pfall++;
            end
            prev_line = tif.line_num;
            prev_phi0 = tif.phi0;

            @(negedge clk);
            apply_inputs(e + 1);
        end

        check_val("releases", releases, 2);
        check_val("drops", drops, 1);
        check_val("frames", frames, 2);
        check_val("pause_rise", prise, 0);
        check_val("pause_fall_seen", 32'(pfall > 0), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
